// File: rtl/reaction_game_ctrl_pkg.sv
// Shared definitions for the reaction-timer game sequencer: one-hot states
// and the default timing constants.
package reaction_game_ctrl_pkg;

  localparam int CNT_W_DEF        = 14;
  localparam int MIN_DELAY_MS_DEF = 200;
  localparam int MAX_MS_DEF       = 9999;
  localparam int HOLDOFF_TK_DEF   = 2;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_ARM    = 6'b000010,
    ST_LIGHTS = 6'b000100,
    ST_DELAY  = 6'b001000,
    ST_REACT  = 6'b010000,
    ST_SHOW   = 6'b100000
  } state_t;

endpackage

// File: rtl/reaction_game_ctrl_ms_counter.sv
// Loadable up/down millisecond counter. Counts only on tick; saturates at
// zero when counting down and at LIMIT when counting up.
module reaction_game_ctrl_ms_counter #(
  parameter int CNT_W = 14,
  parameter int LIMIT = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             up,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: clear beats load beats tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (tick) begin
      if (up) begin
        if (cnt_r < LIM) cnt_r <= cnt_r + CNT_W'(1);
        else             cnt_r <= cnt_r;
      end else begin
        if (cnt_r != '0) cnt_r <= cnt_r - CNT_W'(1);
        else             cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt      = cnt_r;
  assign zero     = (cnt_r == '0);
  assign at_limit = (cnt_r == LIM);

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-timer game sequencer: starts the lights, runs the random delay,
// measures the reaction, flags jump starts and keeps the best time.
module reaction_game_ctrl
  import reaction_game_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
  parameter int MAX_MS       = MAX_MS_DEF,
  parameter int HOLDOFF_TK   = HOLDOFF_TK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_ms,
  input  logic             lights_tk,
  input  logic             start_req,
  input  logic             react_req,
  input  logic             start_delay,
  input  logic [CNT_W-1:0] lfsr_val,
  input  logic             en_lfsr_in,
  output logic             trigger,
  output logic             timeout,
  output logic [CNT_W-1:0] time_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic             result_valid,
  output logic             false_start,
  output logic             busy
);

  localparam int HO_W = $clog2(HOLDOFF_TK + 1);
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_DELAY_MS);
  localparam logic [HO_W-1:0]  HO_LAST = HO_W'(HOLDOFF_TK - 1);

  state_t           state_r;
  logic             sd_prev_r;
  logic [HO_W-1:0]  holdoff_r;
  logic             trigger_r, timeout_r, result_valid_r, false_start_r, busy_r;
  logic [CNT_W-1:0] time_ms_r, best_ms_r;

  logic             sd_rise_s, expire_s;
  logic             cnt_clr_s, cnt_load_s, cnt_tick_s, cnt_up_s;
  logic [CNT_W-1:0] load_val_s, cnt_s;
  logic             cnt_zero_s, cnt_at_limit_s;
  logic             unused_s;

  assign unused_s = en_lfsr_in;

  reaction_game_ctrl_ms_counter #(.CNT_W(CNT_W), .LIMIT(MAX_MS)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (load_val_s),
    .tick     (cnt_tick_s),
    .up       (cnt_up_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s),
    .at_limit (cnt_at_limit_s)
  );

  // Counter steering: the delay expires on the tick that exhausts it.
  always_comb begin
    sd_rise_s  = start_delay & ~sd_prev_r;
    expire_s   = tick_ms & (cnt_zero_s | (cnt_s == CNT_W'(1)));
    load_val_s = (lfsr_val < MIN_V) ? MIN_V : lfsr_val;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_tick_s = 1'b0;
    cnt_up_s   = 1'b0;
    case (state_r)
      ST_ARM, ST_LIGHTS: begin
        if (!react_req && sd_rise_s) cnt_load_s = 1'b1;
        else                         cnt_load_s = 1'b0;
      end
      ST_DELAY: begin
        if (react_req)     cnt_tick_s = 1'b0;
        else if (expire_s) cnt_clr_s  = 1'b1;
        else               cnt_tick_s = tick_ms;
      end
      ST_REACT: begin
        cnt_up_s = 1'b1;
        if (react_req || cnt_at_limit_s) cnt_tick_s = 1'b0;
        else                             cnt_tick_s = tick_ms;
      end
      default: cnt_clr_s = 1'b1;
    endcase
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      sd_prev_r      <= 1'b0;
      holdoff_r      <= '0;
      trigger_r      <= 1'b0;
      timeout_r      <= 1'b0;
      time_ms_r      <= '0;
      best_ms_r      <= '1;
      result_valid_r <= 1'b0;
      false_start_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      sd_prev_r <= start_delay;
      case (state_r)
        ST_IDLE: begin
          if (start_req) begin
            state_r        <= ST_ARM;
            trigger_r      <= 1'b1;
            result_valid_r <= 1'b0;
            false_start_r  <= 1'b0;
            busy_r         <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARM, ST_LIGHTS: begin
          if (react_req) begin
            state_r        <= ST_SHOW;
            trigger_r      <= 1'b0;
            timeout_r      <= 1'b1;
            false_start_r  <= 1'b1;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            holdoff_r      <= '0;
          end else if (sd_rise_s) begin
            state_r   <= ST_DELAY;
            trigger_r <= 1'b0;
          end else if (lights_tk) begin
            state_r <= ST_LIGHTS;
          end else begin
            state_r <= state_r;
          end
        end
        ST_DELAY: begin
          if (react_req) begin
            state_r        <= ST_SHOW;
            timeout_r      <= 1'b1;
            false_start_r  <= 1'b1;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            holdoff_r      <= '0;
          end else if (expire_s) begin
            state_r   <= ST_REACT;
            timeout_r <= 1'b1;
          end else begin
            state_r <= ST_DELAY;
          end
        end
        ST_REACT: begin
          if (react_req || cnt_at_limit_s) begin
            state_r        <= ST_SHOW;
            time_ms_r      <= cnt_s;
            result_valid_r <= 1'b1;
            busy_r         <= 1'b0;
            holdoff_r      <= '0;
            // A timed-out round never counts towards the best time.
            if (react_req && (cnt_s < best_ms_r)) best_ms_r <= cnt_s;
            else                                  best_ms_r <= best_ms_r;
          end else begin
            state_r <= ST_REACT;
          end
        end
        ST_SHOW: begin
          if (timeout_r) begin
            if (lights_tk && (holdoff_r == HO_LAST)) begin
              timeout_r <= 1'b0;
              holdoff_r <= '0;
            end else if (lights_tk) begin
              holdoff_r <= holdoff_r + HO_W'(1);
            end else begin
              holdoff_r <= holdoff_r;
            end
          end else if (start_req) begin
            state_r        <= ST_ARM;
            trigger_r      <= 1'b1;
            result_valid_r <= 1'b0;
            false_start_r  <= 1'b0;
            busy_r         <= 1'b1;
          end else begin
            state_r <= ST_SHOW;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          trigger_r <= 1'b0;
          timeout_r <= 1'b0;
          busy_r    <= 1'b0;
          holdoff_r <= '0;
        end
      endcase
    end
  end

  assign trigger      = trigger_r;
  assign timeout      = timeout_r;
  assign time_ms      = time_ms_r;
  assign best_ms      = best_ms_r;
  assign result_valid = result_valid_r;
  assign false_start  = false_start_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed self-checking bench for reaction_game_ctrl.
module tb_reaction_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_ms = 1'b0, lights_tk = 1'b0, start_req = 1'b0, react_req = 1'b0;
  logic        start_delay = 1'b0, en_lfsr_in = 1'b0;
  logic [13:0] lfsr_val = 14'd0;
  logic        trigger, timeout, result_valid, false_start, busy;
  logic [13:0] time_ms, best_ms;
  int          total = 0;
  int          bad = 0;

  reaction_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .lights_tk(lights_tk),
    .start_req(start_req), .react_req(react_req), .start_delay(start_delay),
    .lfsr_val(lfsr_val), .en_lfsr_in(en_lfsr_in), .trigger(trigger),
    .timeout(timeout), .time_ms(time_ms), .best_ms(best_ms),
    .result_valid(result_valid), .false_start(false_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1; step(); tick_ms = 1'b0; step();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_round(input logic [13:0] lfsr);
    start_req = 1'b1; step(); start_req = 1'b0;
    lights_tk = 1'b1; step(); lights_tk = 1'b0;
    lfsr_val = lfsr; start_delay = 1'b1; step();
  endtask

  task automatic holdoff();
    for (int i = 0; i < 2; i++) begin
      lights_tk = 1'b1; step(); lights_tk = 1'b0; step();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_trig"}, trigger, 0);
    chk({tag, "_to"}, timeout, 0);
    chk({tag, "_time"}, time_ms, 0);
    chk({tag, "_best"}, best_ms, 16383);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_fs"}, false_start, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    step(); step();
    chk_reset("rst0");
    rst_n = 1'b1; step();

    // Round 1: delay 300, react at 150.
    start_req = 1'b1; step(); start_req = 1'b0;
    chk("r1_trig_on", trigger, 1);
    chk("r1_busy", busy, 1);
    lights_tk = 1'b1; step(); lights_tk = 1'b0;
    chk("r1_trig_lights", trigger, 1);
    lfsr_val = 14'd300; start_delay = 1'b1; step();
    chk("r1_trig_off", trigger, 0);
    ticks(299);
    chk("r1_to_299", timeout, 0);
    ticks(1);
    chk("r1_to_300", timeout, 1);
    start_delay = 1'b0;
    ticks(150);
    react_req = 1'b1; step(); react_req = 1'b0;
    chk("r1_time", time_ms, 150);
    chk("r1_best", best_ms, 150);
    chk("r1_rv", result_valid, 1);
    chk("r1_busy_show", busy, 0);
    chk("r1_to_show", timeout, 1);
    lights_tk = 1'b1; step(); lights_tk = 1'b0; step();
    chk("r1_to_ho1", timeout, 1);
    start_req = 1'b1; step(); start_req = 1'b0;
    chk("r1_early_start", busy, 0);
    lights_tk = 1'b1; step(); lights_tk = 1'b0; step();
    chk("r1_to_ho2", timeout, 0);

    // Round 2: clamped delay, react at 180.
    start_round(14'd5);
    chk("r2_rv_clr", result_valid, 0);
    ticks(199);
    chk("r2_to_199", timeout, 0);
    ticks(1);
    chk("r2_to_200", timeout, 1);
    start_delay = 1'b0;
    ticks(180);
    react_req = 1'b1; step(); react_req = 1'b0;
    chk("r2_time", time_ms, 180);
    chk("r2_best", best_ms, 150);
    holdoff();

    // Round 3: jump start during DELAY.
    start_round(14'd250);
    ticks(10);
    react_req = 1'b1; step(); react_req = 1'b0;
    chk("r3_fs", false_start, 1);
    chk("r3_rv", result_valid, 0);
    chk("r3_time", time_ms, 180);
    chk("r3_best", best_ms, 150);
    chk("r3_trig", trigger, 0);
    chk("r3_to", timeout, 1);
    start_delay = 1'b0;
    start_req = 1'b1; step(); start_req = 1'b0;
    chk("r3_early_start", busy, 0);
    chk("r3_fs_held", false_start, 1);
    holdoff();
    chk("r3_to_off", timeout, 0);

    // Round 4: jump start on the expiry cycle.
    start_round(14'd200);
    ticks(199);
    tick_ms = 1'b1; react_req = 1'b1; step(); tick_ms = 1'b0; react_req = 1'b0;
    chk("r4_fs", false_start, 1);
    chk("r4_time", time_ms, 180);
    start_delay = 1'b0;
    holdoff();

    // Round 5: new best of 120.
    start_round(14'd200);
    ticks(200);
    start_delay = 1'b0;
    ticks(120);
    react_req = 1'b1; step(); react_req = 1'b0;
    chk("r5_fs", false_start, 0);
    chk("r5_time", time_ms, 120);
    chk("r5_best", best_ms, 120);
    holdoff();

    // Round 6: no reaction saturates at 9999.
    start_round(14'd200);
    ticks(200);
    start_delay = 1'b0;
    ticks(9998);
    chk("r6_busy_9998", busy, 1);
    chk("r6_rv_9998", result_valid, 0);
    ticks(1);
    chk("r6_time", time_ms, 9999);
    chk("r6_rv", result_valid, 1);
    chk("r6_best", best_ms, 120);
    chk("r6_busy", busy, 0);
    holdoff();

    // Round 7: reaction coincident with tick at 42.
    start_round(14'd200);
    ticks(200);
    start_delay = 1'b0;
    ticks(42);
    tick_ms = 1'b1; react_req = 1'b1; step(); tick_ms = 1'b0; react_req = 1'b0;
    chk("r7_time", time_ms, 42);
    chk("r7_best", best_ms, 42);
    holdoff();

    // Round 8: reset mid-REACT.
    start_round(14'd200);
    ticks(200);
    start_delay = 1'b0;
    ticks(10);
    chk("r8_busy", busy, 1);
    rst_n = 1'b0; step();
    chk_reset("r8");
    rst_n = 1'b1; step();
    chk("r8_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
